// File: rtl/ddr3_ex_lfsr8_checker_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_ex_lfsr8_checker_pkg
// Shared definitions for the LFSR8 pattern checker:
//   - chk_state_e  : checker FSM states (IDLE / SYNC / CHECK)
//   - LFSR8_TAPS   : feedback tap mask for x^8+x^4+x^3+x^2+1
//   - lfsr8_next() : one Galois step of the pattern sequence
// ---------------------------------------------------------------------------
package ddr3_ex_lfsr8_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } chk_state_e;

  localparam logic [7:0] LFSR8_TAPS = 8'h1D;

  // Shift left; when the outgoing bit 7 is set, bits 0, 2, 3 and 4 are
  // toggled. Bit 0 therefore receives old bit 7.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? LFSR8_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/ddr3_ex_lfsr8_checker.sv
// ---------------------------------------------------------------------------
// ddr3_ex_lfsr8_checker
// Checks a received byte stream against the LFSR8 pattern sequence. The
// checker first synchronises (SYNC_LEN consecutive matches), then flags and
// counts every mismatch while locked.
//
// Parameters:
//   SEED      - LFSR start value in seeded mode (low 8 bits used)
//   SELF_SYNC - 1: expected value seeded from received data; 0: from SEED
//   SYNC_LEN  - consecutive matches needed to lock (1..15)
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   checker active; low returns to IDLE and clears status
//   valid          in   qualifies data this cycle
//   data[7:0]      in   received pattern byte
//   resync         in   one-cycle pulse: back to SYNC (status kept)
//   locked         out  high while in CHECK
//   error          out  sticky mismatch flag
//   err_count[15:0] out saturating mismatch count
//   first_err_data out  received byte of first mismatch
//   first_err_exp  out  expected byte of first mismatch
// Build option:
//   LFSR8_CHK_CAPTURE_EN - when defined, first-mismatch capture registers are
//                          built; otherwise first_err_* are tied to zero.
// ---------------------------------------------------------------------------
module ddr3_ex_lfsr8_checker
  import ddr3_ex_lfsr8_checker_pkg::*;
#(
  parameter int SEED      = 32,
  parameter int SELF_SYNC = 1,
  parameter int SYNC_LEN  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        valid,
  input  logic [7:0]  data,
  input  logic        resync,
  output logic        locked,
  output logic        error,
  output logic [15:0] err_count,
  output logic [7:0]  first_err_data,
  output logic [7:0]  first_err_exp
);

  localparam logic [7:0] SEED_B     = 8'(SEED);
  localparam logic [3:0] SYNC_LEN_C = 4'(SYNC_LEN);

  chk_state_e  state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;
  logic [15:0] err_count_q, err_count_d;
  logic        check_miss;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    err_count_d = err_count_q;
    check_miss  = 1'b0;

    if (!enable) begin
      state_d     = ST_IDLE;
      exp_d       = SEED_B;
      cnt_d       = 4'd0;
      error_d     = 1'b0;
      err_count_d = 16'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
          exp_d   = SEED_B;
          cnt_d   = 4'd0;
        end
        ST_SYNC: begin
          if (resync) begin
            exp_d = SEED_B;
            cnt_d = 4'd0;
          end else if (valid) begin
            // In self-sync mode a zero match count means nothing has been
            // loaded yet, so the byte seeds the sequence and counts as one.
            if (SELF_SYNC != 0 && cnt_q == 4'd0) begin
              exp_d = lfsr8_next(data);
              cnt_d = 4'd1;
            end else if (data == exp_q) begin
              exp_d = lfsr8_next(exp_q);
              cnt_d = 4'(cnt_q + 4'd1);
            end else if (SELF_SYNC != 0) begin
              exp_d = lfsr8_next(data);
              cnt_d = 4'd1;
            end else begin
              exp_d = SEED_B;
              cnt_d = 4'd0;
            end
            if (cnt_d >= SYNC_LEN_C) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (resync) begin
            state_d = ST_SYNC;
            exp_d   = SEED_B;
            cnt_d   = 4'd0;
          end else if (valid) begin
            exp_d = lfsr8_next(exp_q);
            if (data != exp_q) begin
              check_miss = 1'b1;
              error_d    = 1'b1;
              if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          exp_d   = SEED_B;
          cnt_d   = 4'd0;
        end
      endcase
    end

    locked_d = (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      exp_q       <= SEED_B;
      cnt_q       <= 4'd0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;

`ifdef LFSR8_CHK_CAPTURE_EN
  logic [7:0] cap_data_q, cap_data_d;
  logic [7:0] cap_exp_q, cap_exp_d;

  // error_q is cleared only by reset or enable-low, so a miss while it is
  // still low is the first one since the last clear.
  always_comb begin
    cap_data_d = cap_data_q;
    cap_exp_d  = cap_exp_q;
    if (!enable) begin
      cap_data_d = 8'd0;
      cap_exp_d  = 8'd0;
    end else if (check_miss && !error_q) begin
      cap_data_d = data;
      cap_exp_d  = exp_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_data_q <= 8'd0;
      cap_exp_q  <= 8'd0;
    end else begin
      cap_data_q <= cap_data_d;
      cap_exp_q  <= cap_exp_d;
    end
  end

  assign first_err_data = cap_data_q;
  assign first_err_exp  = cap_exp_q;
`else
  logic unused_miss;
  assign unused_miss    = check_miss;
  assign first_err_data = 8'd0;
  assign first_err_exp  = 8'd0;
`endif

endmodule

// File: doc/ddr3_ex_lfsr8_checker.md
DDR3_EX_LFSR8_CHECKER -- requirements
Module: ddr3_ex_lfsr8_checker

Interface
REQ-001 SHALL have parameter SEED, default 32, the LFSR start value in seeded mode (low 8 bits used).
REQ-002 SHALL have parameter SELF_SYNC, default 1: 1 means expected state loads from the received data; 0 means expected state starts at SEED.
REQ-003 SHALL have parameter SYNC_LEN, default 4, the consecutive matches required to lock (range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: checker active; low forces IDLE.
REQ-007 SHALL have port valid, input, 1 bit: data qualifier for the current cycle.
REQ-008 SHALL have port data, input, 8 bits: received pattern byte.
REQ-009 SHALL have port resync, input, 1 bit: one-cycle pulse that returns the checker to SYNC.
REQ-010 SHALL have port locked, output, 1 bit: high while in CHECK.
REQ-011 SHALL have port error, output, 1 bit: sticky mismatch flag.
REQ-012 SHALL have port err_count, output, 16 bits: saturating count of mismatches.
REQ-013 SHALL have port first_err_data, output, 8 bits: received byte of the first mismatch.
REQ-014 SHALL have port first_err_exp, output, 8 bits: expected byte of the first mismatch.

Function
REQ-015 SHALL compute the next expected value as a left shift of the current value, with bits 0, 2, 3 and 4 XORed with old bit 7 (polynomial x^8+x^4+x^3+x^2+1). Bit 0 takes old bit 7, so this is the same sequence as the team's lfsr8 generator.
REQ-016 SHALL use an FSM with states IDLE, SYNC and CHECK.
REQ-017 In IDLE, the expected value SHALL be held at SEED[7:0], the match counter SHALL be 0, and the FSM SHALL move to SYNC on the first cycle enable is high.
REQ-018 In SYNC with SELF_SYNC=1, the first valid byte SHALL load the expected register with next(data) and set the match counter to 1; each later valid byte SHALL be compared against expected.
REQ-019 In SYNC with SELF_SYNC=0, every valid byte SHALL be compared against expected, starting from SEED.
REQ-020 In SYNC, a match SHALL increment the match counter and advance expected; on reaching SYNC_LEN the FSM SHALL enter CHECK in the next cycle.
REQ-021 In SYNC, a mismatch SHALL reload expected (next(data) when SELF_SYNC=1; SEED when SELF_SYNC=0) and reset the match counter accordingly; it SHALL NOT count as an error.
REQ-022 In CHECK, each valid byte SHALL be compared and expected SHALL always advance. On a mismatch, error SHALL be set and err_count SHALL increment, saturating at 0xFFFF.
REQ-023 All outputs SHALL be registered; status SHALL update on the clock edge that samples the valid byte (one-cycle latency).
REQ-024 When valid is low, expected, the match counter and the FSM state SHALL hold (pause).
REQ-025 resync SHALL force SYNC, clear the match counter and reload expected; it SHALL NOT clear error, err_count or the capture registers. If resync and valid coincide, the byte SHALL be ignored.
REQ-026 enable low SHALL return the FSM to IDLE from any state within one cycle and SHALL clear error, err_count and the capture registers; enable low has priority over resync.

Reset
REQ-027 Asserting reset_n low SHALL asynchronously force IDLE, expected=SEED[7:0], locked=0, error=0, err_count=0, first_err_data=0 and first_err_exp=0.

Configuration
REQ-028 With macro LFSR8_CHK_CAPTURE_EN defined, first_err_data and first_err_exp SHALL latch on the first CHECK mismatch after reset or enable-low and hold until cleared.
REQ-029 Without LFSR8_CHK_CAPTURE_EN, first_err_data and first_err_exp SHALL be constant 0 and no capture registers SHALL exist.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef, the tap mask constant 8'h1D, and an lfsr8_next function.
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 Defaults, enable=1, valid stream 0x20,0x40,0x80,0x1D,0x3A -> locked=1 after the 4th match; error=0; err_count=0.
REQ-033 Locked, then received 0x74,0xE9 (expected 0xE8) -> error=1, err_count=1, first_err_data=0xE9, first_err_exp=0xE8; the next byte 0xCD is accepted as a match.
REQ-034 Locked, valid low for 10 cycles, then resume with 0x74 -> no error.
REQ-035 SELF_SYNC=0, stream starting 0x55 -> remains in SYNC, locked=0, err_count=0.
REQ-036 Force err_count=0xFFFF, then one more mismatch -> err_count stays 0xFFFF; reset_n pulsed mid-stream -> all outputs return to the reset values of REQ-027 immediately.
REQ-037 Pulse resync while locked -> locked=0 next cycle, error retained, relock after 4 matches.
